// File: rtl/ase_pcie_ss_rd_tag_mgr_pkg.sv
// Shared ASE PCIe SS types: tag state, per-tag bookkeeping entry, error codes
// and the emulator runtime configuration used to size the read tag manager.
package ase_pcie_ss_rd_tag_mgr_pkg;

    localparam int AFU_TAG_W = 10;
    localparam int LEN_W     = 13;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } t_tag_state;

    typedef struct packed {
        logic [AFU_TAG_W-1:0] afu_tag;
        logic [LEN_W-1:0]     remaining;
    } t_tag_entry;

    typedef enum logic [1:0] {
        ERR_UNKNOWN_TAG = 2'd0,
        ERR_OVERRUN     = 2'd1,
        ERR_ZERO_LEN    = 2'd2,
        ERR_TAG_RANGE   = 2'd3
    } t_err_code;

    typedef struct packed {
        int unsigned max_outstanding_dma_rd;
        logic        emulate_tag_mapper;
    } t_ase_pcie_ss_cfg;

    localparam t_ase_pcie_ss_cfg ASE_PCIE_SS_DFLT_CFG = '{
        max_outstanding_dma_rd: 64,
        emulate_tag_mapper:     1'b1
    };

endpackage

// File: rtl/ase_pcie_ss_rd_tag_mgr_if.sv
// Request / completion / response bundle between the AFU read path, the tag
// manager and the host-memory completion generator.
interface ase_pcie_ss_rd_tag_mgr_if #(
    parameter int AFU_TAG_W = 10,
    parameter int LEN_W     = 13,
    parameter int TAG_W     = 6
);
    // Request handshake: a request transfers on a cycle where req_valid and
    // req_ready are both high; req_int_tag is meaningful on that same cycle.
    logic                 req_valid;
    logic                 req_ready;
    logic [AFU_TAG_W-1:0] req_afu_tag;
    logic [LEN_W-1:0]     req_len;
    logic [TAG_W-1:0]     req_int_tag;

    logic                 cpl_valid;
    logic [TAG_W-1:0]     cpl_int_tag;
    logic [LEN_W-1:0]     cpl_bytes;

    logic                 rsp_valid;
    logic [AFU_TAG_W-1:0] rsp_afu_tag;
    logic                 rsp_last;
    logic [TAG_W:0]       num_outstanding;
    logic                 err_pulse;
    logic [1:0]           err_code;

    modport master (
        output req_valid, req_afu_tag, req_len, cpl_valid, cpl_int_tag, cpl_bytes,
        input  req_ready, req_int_tag, rsp_valid, rsp_afu_tag, rsp_last,
               num_outstanding, err_pulse, err_code
    );

    modport slave (
        input  req_valid, req_afu_tag, req_len, cpl_valid, cpl_int_tag, cpl_bytes,
        output req_ready, req_int_tag, rsp_valid, rsp_afu_tag, rsp_last,
               num_outstanding, err_pulse, err_code
    );
endinterface

// File: rtl/ase_pcie_ss_find_first_free.sv
// Lowest-set-bit priority encoder with a found flag.
module ase_pcie_ss_find_first_free #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ase_pcie_ss_rd_tag_mgr.sv
// Outstanding DMA read tracker: allocates internal tags, remembers AFU tag and
// remaining bytes, retires tags as completion chunks arrive.
module ase_pcie_ss_rd_tag_mgr
    import ase_pcie_ss_rd_tag_mgr_pkg::*;
#(
    parameter int MAX_TAGS           = int'(ASE_PCIE_SS_DFLT_CFG.max_outstanding_dma_rd),
    parameter bit EMULATE_TAG_MAPPER = ASE_PCIE_SS_DFLT_CFG.emulate_tag_mapper
) (
    input  logic                   clk,
    input  logic                   reset,
    ase_pcie_ss_rd_tag_mgr_if.slave bus,
    output logic [MAX_TAGS-1:0]    dbg_tag_busy
);

    localparam int TAG_W = $clog2(MAX_TAGS);
    localparam int CNT_W = TAG_W + 1;

    t_tag_state tag_state_q [MAX_TAGS];
    t_tag_state tag_state_d [MAX_TAGS];
    t_tag_entry entry_q     [MAX_TAGS];

    logic                run_q;
    logic [CNT_W-1:0]    num_q;
    logic [MAX_TAGS-1:0] free_vec;
    logic [TAG_W-1:0]    free_idx;
    logic                any_free;

    logic                ready, zero_len, tag_out_of_range, fire;
    logic                accept_alloc, req_err;
    logic [TAG_W-1:0]    req_tag;
    t_err_code           req_code;

    logic                cpl_hit, cpl_overrun, retire, cpl_err;
    logic [LEN_W-1:0]    cpl_rem;
    t_err_code           cpl_code;

    always_comb begin
        for (int i = 0; i < MAX_TAGS; i++) begin
            free_vec[i]     = (tag_state_q[i] == FREE);
            dbg_tag_busy[i] = (tag_state_q[i] == BUSY);
        end
    end

    ase_pcie_ss_find_first_free #(.N(MAX_TAGS), .W(TAG_W)) u_ffs (
        .vec   (free_vec),
        .idx   (free_idx),
        .found (any_free)
    );

    // Zero-length and out-of-range requests are always taken and dropped so
    // they never hold up the requester.
    always_comb begin
        zero_len         = (bus.req_len == '0);
        tag_out_of_range = 1'b0;
        req_tag          = free_idx;
        ready            = 1'b0;
        if (EMULATE_TAG_MAPPER) begin
            ready = run_q && (any_free || zero_len);
        end else begin
            req_tag          = bus.req_afu_tag[TAG_W-1:0];
            tag_out_of_range = int'(bus.req_afu_tag) >= MAX_TAGS;
            ready            = run_q && (tag_out_of_range || zero_len ||
                                         tag_state_q[req_tag] == FREE);
        end
        fire         = bus.req_valid && ready;
        accept_alloc = fire && !zero_len && !tag_out_of_range;
        req_err      = fire && (zero_len || tag_out_of_range);
        req_code     = tag_out_of_range ? ERR_TAG_RANGE : ERR_ZERO_LEN;
    end

    always_comb begin
        cpl_rem     = entry_q[bus.cpl_int_tag].remaining;
        cpl_hit     = bus.cpl_valid && (tag_state_q[bus.cpl_int_tag] == BUSY);
        cpl_overrun = cpl_hit && (bus.cpl_bytes > cpl_rem);
        retire      = cpl_hit && (bus.cpl_bytes >= cpl_rem);
        cpl_err     = (bus.cpl_valid && !cpl_hit) || cpl_overrun;
        cpl_code    = cpl_hit ? ERR_OVERRUN : ERR_UNKNOWN_TAG;
    end

    // Allocation only ever picks FREE tags and retirement only BUSY ones, so
    // the two updates never target the same tag.
    always_comb begin
        tag_state_d = tag_state_q;
        if (accept_alloc) tag_state_d[req_tag] = BUSY;
        if (retire)       tag_state_d[bus.cpl_int_tag] = FREE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_TAGS; i++) tag_state_q[i] <= FREE;
            run_q           <= 1'b0;
            num_q           <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_afu_tag <= '0;
            bus.rsp_last    <= 1'b0;
            bus.err_pulse   <= 1'b0;
            bus.err_code    <= '0;
        end else begin
            tag_state_q   <= tag_state_d;
            run_q         <= 1'b1;
            num_q         <= num_q + CNT_W'(accept_alloc) - CNT_W'(retire);
            bus.rsp_valid <= cpl_hit;
            bus.rsp_last  <= retire;
            if (cpl_hit) bus.rsp_afu_tag <= entry_q[bus.cpl_int_tag].afu_tag;
            bus.err_pulse <= cpl_err || req_err;
            if (cpl_err)      bus.err_code <= cpl_code;
            else if (req_err) bus.err_code <= req_code;
        end
    end

    // Entry payload is only meaningful while its tag is BUSY, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept_alloc) entry_q[req_tag] <= '{afu_tag: bus.req_afu_tag, remaining: bus.req_len};
        if (cpl_hit && !retire) entry_q[bus.cpl_int_tag].remaining <= cpl_rem - bus.cpl_bytes;
    end

    assign bus.req_ready       = ready;
    assign bus.req_int_tag     = req_tag;
    assign bus.num_outstanding = num_q;

endmodule

// File: tb/tb_ase_pcie_ss_rd_tag_mgr.sv
// Directed bench for the read tag manager: one instance with the tag mapper
// emulated, one with internal tag equal to AFU tag.
module tb_ase_pcie_ss_rd_tag_mgr;
    import ase_pcie_ss_rd_tag_mgr_pkg::*;

    localparam t_ase_pcie_ss_cfg CFG_NOMAP = '{max_outstanding_dma_rd: 64, emulate_tag_mapper: 1'b0};
    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ase_pcie_ss_rd_tag_mgr_if #(.AFU_TAG_W(AFU_TAG_W), .LEN_W(LEN_W), .TAG_W(TAG_W)) bus_m ();
    ase_pcie_ss_rd_tag_mgr_if #(.AFU_TAG_W(AFU_TAG_W), .LEN_W(LEN_W), .TAG_W(TAG_W)) bus_n ();
    logic [63:0] dbg_m, dbg_n;

    ase_pcie_ss_rd_tag_mgr u_dut_map (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_m.slave),
        .dbg_tag_busy (dbg_m)
    );

    ase_pcie_ss_rd_tag_mgr #(
        .MAX_TAGS           (int'(CFG_NOMAP.max_outstanding_dma_rd)),
        .EMULATE_TAG_MAPPER (CFG_NOMAP.emulate_tag_mapper)
    ) u_dut_nomap (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_n.slave),
        .dbg_tag_busy (dbg_n)
    );

    typedef struct {
        int rv, afu, len, cv, ctag, cbytes;
        int e_rdy, e_tag, e_rv, e_afu, e_last, e_num, e_ep, e_ec;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int rv, input int afu, input int len,
                           input int cv, input int ctag, input int cb);
        bus_m.req_valid   = rv[0];
        bus_m.req_afu_tag = AFU_TAG_W'(afu);
        bus_m.req_len     = LEN_W'(len);
        bus_m.cpl_valid   = cv[0];
        bus_m.cpl_int_tag = TAG_W'(ctag);
        bus_m.cpl_bytes   = LEN_W'(cb);
    endtask

    task automatic drive_n(input int rv, input int afu, input int len,
                           input int cv, input int ctag, input int cb);
        bus_n.req_valid   = rv[0];
        bus_n.req_afu_tag = AFU_TAG_W'(afu);
        bus_n.req_len     = LEN_W'(len);
        bus_n.cpl_valid   = cv[0];
        bus_n.cpl_int_tag = TAG_W'(ctag);
        bus_n.cpl_bytes   = LEN_W'(cb);
    endtask

    initial begin
        //            rv  afu    len  cv tag bytes rdy itag rv  afu    last num ep  ec
        vecs[0]  = '{1, 'h3FF, 128, 0, 0, 0,    1, 0,   0, -1,    -1,  1,  0, -1};
        vecs[1]  = '{1, 'h3FF, 128, 0, 0, 0,    1, 1,   0, -1,    -1,  2,  0, -1};
        vecs[2]  = '{1, 'h005, 128, 0, 0, 0,    1, 2,   0, -1,    -1,  3,  0, -1};
        vecs[3]  = '{0, 0,     0,   1, 1, 64,   1, 3,   1, 'h3FF, 0,   3,  0, -1};
        vecs[4]  = '{0, 0,     0,   1, 1, 64,   1, 3,   1, 'h3FF, 1,   2,  0, -1};
        vecs[5]  = '{1, 'h011, 64,  0, 0, 0,    1, 1,   0, -1,    -1,  3,  0, -1};
        vecs[6]  = '{0, 0,     0,   1, 2, 256,  1, 3,   1, 'h005, 1,   2,  1, 1};
        vecs[7]  = '{0, 0,     0,   1, 9, 64,   1, 2,   0, -1,    -1,  2,  1, 0};
        vecs[8]  = '{1, 7,     0,   0, 0, 0,    1, 2,   0, -1,    -1,  2,  1, 2};
        vecs[9]  = '{0, 0,     0,   0, 0, 0,    1, 2,   0, -1,    -1,  2,  0, -1};
        vecs[10] = '{1, 'h020, 32,  1, 0, 128,  1, 2,   1, 'h3FF, 1,   2,  0, -1};
        vecs[11] = '{0, 0,     0,   1, 1, 64,   1, 0,   1, 'h011, 1,   1,  0, -1};
        vecs[12] = '{1, 7,     0,   1, 9, 64,   1, 0,   0, -1,    -1,  1,  1, 0};
        vecs[13] = '{0, 0,     0,   1, 2, 32,   1, 0,   1, 'h020, 1,   0,  0, -1};

        drive_m(0, 0, 0, 0, 0, 0);
        drive_n(0, 0, 0, 0, 0, 0);

        // Reset values
        tick();
        chk("rst.ready_m", bus_m.req_ready, 0);
        chk("rst.ready_n", bus_n.req_ready, 0);
        chk("rst.num_m", bus_m.num_outstanding, 0);
        chk("rst.rsp_valid", bus_m.rsp_valid, 0);
        chk("rst.rsp_last", bus_m.rsp_last, 0);
        chk("rst.rsp_afu", bus_m.rsp_afu_tag, 0);
        chk("rst.err_pulse", bus_m.err_pulse, 0);
        chk("rst.err_code", bus_m.err_code, 0);
        reset = 1'b0;
        tick();
        chk("post_rst.ready_m", bus_m.req_ready, 1);
        chk("post_rst.ready_n", bus_n.req_ready, 1);

        // Table: mapper on
        for (int i = 0; i < 14; i++) begin
            drive_m(vecs[i].rv, vecs[i].afu, vecs[i].len, vecs[i].cv, vecs[i].ctag, vecs[i].cbytes);
            #1;
            chk($sformatf("v%0d.ready", i), bus_m.req_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d.int_tag", i), bus_m.req_int_tag, vecs[i].e_tag);
            tick();
            chk($sformatf("v%0d.rsp_valid", i), bus_m.rsp_valid, vecs[i].e_rv);
            if (vecs[i].e_afu >= 0) chk($sformatf("v%0d.rsp_afu", i), bus_m.rsp_afu_tag, vecs[i].e_afu);
            if (vecs[i].e_last >= 0) chk($sformatf("v%0d.rsp_last", i), bus_m.rsp_last, vecs[i].e_last);
            chk($sformatf("v%0d.num", i), bus_m.num_outstanding, vecs[i].e_num);
            chk($sformatf("v%0d.err_pulse", i), bus_m.err_pulse, vecs[i].e_ep);
            if (vecs[i].e_ec >= 0) chk($sformatf("v%0d.err_code", i), bus_m.err_code, vecs[i].e_ec);
        end

        // Fill all 64 tags, stall the 65th, retire tag 17 and reuse it
        for (int i = 0; i < 64; i++) begin
            drive_m(1, i, 16, 0, 0, 0);
            #1;
            chk($sformatf("fill%0d.ready", i), bus_m.req_ready, 1);
            chk($sformatf("fill%0d.int_tag", i), bus_m.req_int_tag, i);
            tick();
        end
        chk("fill.num", bus_m.num_outstanding, 64);
        drive_m(1, 100, 16, 0, 0, 0);
        #1;
        chk("full.ready", bus_m.req_ready, 0);
        tick();
        chk("full.num", bus_m.num_outstanding, 64);
        drive_m(1, 100, 16, 1, 17, 16);
        #1;
        chk("retire17.ready_same_cycle", bus_m.req_ready, 0);
        tick();
        chk("retire17.rsp_valid", bus_m.rsp_valid, 1);
        chk("retire17.rsp_afu", bus_m.rsp_afu_tag, 17);
        chk("retire17.rsp_last", bus_m.rsp_last, 1);
        chk("retire17.num", bus_m.num_outstanding, 63);
        drive_m(1, 100, 16, 0, 0, 0);
        #1;
        chk("reuse17.ready", bus_m.req_ready, 1);
        chk("reuse17.int_tag", bus_m.req_int_tag, 17);
        tick();
        chk("reuse17.num", bus_m.num_outstanding, 64);

        // Clean restart, 10 tags busy, then reset mid-operation
        drive_m(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("rst2.num", bus_m.num_outstanding, 0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive_m(1, 'h200 + i, 16, 0, 0, 0);
            tick();
        end
        chk("busy10.num", bus_m.num_outstanding, 10);
        drive_m(0, 0, 0, 1, 3, 16);
        reset = 1'b1;
        #1;
        chk("midrst.num", bus_m.num_outstanding, 0);
        chk("midrst.ready", bus_m.req_ready, 0);
        chk("midrst.rsp_valid", bus_m.rsp_valid, 0);
        tick();
        chk("midrst.rsp_valid_hold", bus_m.rsp_valid, 0);
        tick();
        reset = 1'b0;
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
        chk("after_rst.ready", bus_m.req_ready, 1);
        chk("after_rst.rsp_valid", bus_m.rsp_valid, 0);
        drive_m(1, 'h123, 8, 0, 0, 0);
        #1;
        chk("after_rst.int_tag", bus_m.req_int_tag, 0);
        tick();
        chk("after_rst.num", bus_m.num_outstanding, 1);
        drive_m(0, 0, 0, 0, 0, 0);

        // Mapper off
        drive_n(1, 5, 128, 0, 0, 0);
        #1;
        chk("nm.first.ready", bus_n.req_ready, 1);
        chk("nm.first.int_tag", bus_n.req_int_tag, 5);
        tick();
        chk("nm.first.num", bus_n.num_outstanding, 1);
        drive_n(1, 5, 64, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("nm.stall%0d.ready", k), bus_n.req_ready, 0);
            tick();
            chk($sformatf("nm.stall%0d.num", k), bus_n.num_outstanding, 1);
        end
        drive_n(1, 5, 64, 1, 5, 128);
        #1;
        chk("nm.retire.ready_same_cycle", bus_n.req_ready, 0);
        tick();
        chk("nm.retire.rsp_valid", bus_n.rsp_valid, 1);
        chk("nm.retire.rsp_afu", bus_n.rsp_afu_tag, 5);
        chk("nm.retire.rsp_last", bus_n.rsp_last, 1);
        chk("nm.retire.num", bus_n.num_outstanding, 0);
        drive_n(1, 5, 64, 0, 0, 0);
        #1;
        chk("nm.second.ready", bus_n.req_ready, 1);
        chk("nm.second.int_tag", bus_n.req_int_tag, 5);
        tick();
        chk("nm.second.num", bus_n.num_outstanding, 1);
        drive_n(1, 70, 64, 0, 0, 0);
        #1;
        chk("nm.range.ready", bus_n.req_ready, 1);
        tick();
        chk("nm.range.err_pulse", bus_n.err_pulse, 1);
        chk("nm.range.err_code", bus_n.err_code, 3);
        chk("nm.range.num", bus_n.num_outstanding, 1);
        chk("nm.range.rsp_valid", bus_n.rsp_valid, 0);
        drive_n(0, 0, 0, 1, 5, 64);
        tick();
        chk("nm.final.rsp_last", bus_n.rsp_last, 1);
        chk("nm.final.num", bus_n.num_outstanding, 0);
        chk("nm.final.err_pulse", bus_n.err_pulse, 0);
        drive_n(0, 0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
